pst_wb: RTL

- Writeback stage of the five-stage pipelined core. It is the writer end of the register-file write port that the decode stage consumes.
- Latches the MEM/WB pipeline register and extends load data by access type.
- Selects the value to write (ALU, load, PC+4) and drives the RF write triple (we, req_w, data_w) back to decode.
- Also retires syscalls (halt / display) and counts retired instructions.

---
 rtl/pst_wb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pst_wb.sv
// Writeback stage: latches the MEM/WB register, extends load data and drives the
// register-file write port back to decode. Also retires syscalls and counts retired instructions.
module pst_wb #(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] SYSCALL_HALT = 32'd10,
    parameter logic [31:0] SYSCALL_SHOW = 32'd34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_rf_we,
    input  logic [4:0]       in_rf_req_w,
    input  logic [1:0]       in_mux_rf_data_w,
    input  logic [31:0]      in_alu_data,
    input  logic [31:0]      in_dm_data,
    input  logic [2:0]       in_dm_op,
    input  logic [31:0]      in_pc_4,
    input  logic             in_syscall_en,
    input  logic [31:0]      in_rf_data_v0,
    input  logic [31:0]      in_rf_data_a0,
    output logic             rf_we,
    output logic [4:0]       rf_req_w,
    output logic [31:0]      rf_data_w,
    output logic             halt,
    output logic [31:0]      display,
    output logic [CNT_W-1:0] retired
);

    logic             r_valid;
    logic             r_we;
    logic [4:0]       r_req_w;
    logic [1:0]       r_mux;
    logic [31:0]      r_alu_data;
    logic [31:0]      r_dm_data;
    logic [2:0]       r_dm_op;
    logic [31:0]      r_pc_4;
    logic             r_halt;
    logic [31:0]      r_display;
    logic [CNT_W-1:0] r_retired;

    logic             w_adv;
    logic             w_take;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_sel;

    assign w_adv  = en & ~r_halt;
    // A real instruction enters WB only when it is valid and not being flushed.
    assign w_take = w_adv & ~flush & in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_req_w    <= 5'd0;
            r_mux      <= 2'd0;
            r_alu_data <= 32'd0;
            r_dm_data  <= 32'd0;
            r_dm_op    <= 3'd0;
            r_pc_4     <= 32'd0;
            r_halt     <= 1'b0;
            r_display  <= 32'd0;
            r_retired  <= '0;
        end else if (w_adv) begin
            if (flush) begin
                r_valid    <= 1'b0;
                r_we       <= 1'b0;
                r_req_w    <= 5'd0;
                r_mux      <= 2'd0;
                r_alu_data <= 32'd0;
                r_dm_data  <= 32'd0;
                r_dm_op    <= 3'd0;
                r_pc_4     <= 32'd0;
            end else begin
                r_valid    <= in_valid;
                r_we       <= in_rf_we;
                r_req_w    <= in_rf_req_w;
                r_mux      <= in_mux_rf_data_w;
                r_alu_data <= in_alu_data;
                r_dm_data  <= in_dm_data;
                r_dm_op    <= in_dm_op;
                r_pc_4     <= in_pc_4;
            end
            if (w_take) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
                if (in_syscall_en && in_rf_data_v0 == SYSCALL_HALT) begin
                    r_halt <= 1'b1;
                end
                if (in_syscall_en && in_rf_data_v0 == SYSCALL_SHOW) begin
                    r_display <= in_rf_data_a0;
                end
            end
        end
    end

    // Little-endian lane select; half-word uses only offset bit 1, misalignment is not trapped.
    assign w_byte = r_dm_data[{r_alu_data[1:0], 3'b000} +: 8];
    assign w_half = r_alu_data[1] ? r_dm_data[31:16] : r_dm_data[15:0];

    always_comb begin
        w_load = r_dm_data;
        case (r_dm_op)
            3'd1:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd2:    w_load = {24'd0, w_byte};
            3'd3:    w_load = {{16{w_half[15]}}, w_half};
            3'd4:    w_load = {16'd0, w_half};
            default: w_load = r_dm_data;
        endcase
    end

    always_comb begin
        w_sel = 32'd0;
        case (r_mux)
            2'd0:    w_sel = r_alu_data;
            2'd1:    w_sel = w_load;
            2'd2:    w_sel = r_pc_4;
            default: w_sel = 32'd0;
        endcase
    end

    assign rf_we     = r_valid & r_we & (r_req_w != 5'd0);
    assign rf_req_w  = r_valid ? r_req_w : 5'd0;
    assign rf_data_w = r_valid ? w_sel : 32'd0;
    assign halt      = r_halt;
    assign display   = r_display;
    assign retired   = r_retired;

endmodule
